// File: rtl/pll_dyn_ctrl.sv
// PLL dynamic-divider sequencer: programs divider codes, pulses PLL reset, supervises lock with timeout/retry.
// Define PLL_DYN_CTRL_LOCK_MON_EN to reprogram on lock loss in RUN and count those events in relock_cnt_o.
module pll_dyn_ctrl #(
    parameter int          RST_CYCLES     = 16,
    parameter int          TIMEOUT_CYCLES = 24000,
    parameter int          SETTLE_CYCLES  = 240,
    parameter int          MAX_RETRY      = 3,
    parameter int          CNT_W          = 16,
    parameter logic [5:0]  INIT_IDSEL     = 6'd0,
    parameter logic [5:0]  INIT_FBDSEL    = 6'd0,
    parameter logic [5:0]  INIT_ODSEL     = 6'd0
) (
    input  logic       clkin_i,
    input  logic       reset_i,
    input  logic       cfg_valid_i,
    output logic       cfg_ready_o,
    input  logic [5:0] cfg_idsel_i,
    input  logic [5:0] cfg_fbdsel_i,
    input  logic [5:0] cfg_odsel_i,
    input  logic       pll_lock_i,
    output logic       pll_reset_o,
    output logic [5:0] pll_idsel_o,
    output logic [5:0] pll_fbdsel_o,
    output logic [5:0] pll_odsel_o,
    output logic       clk_good_o,
    output logic       busy_o,
    output logic       err_o,
    output logic [7:0] relock_cnt_o,
    output logic [2:0] state_o
);

    localparam logic [2:0] S_RST    = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_ERROR  = 3'd4;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [7:0]       RETRY_MAX   = 8'(MAX_RETRY);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       retry_q, retry_d;
    logic [5:0]       idsel_q, idsel_d, fbdsel_q, fbdsel_d, odsel_q, odsel_d;
    logic             sync1_q, sync2_q, lock_s;
    logic             pll_reset_q, clk_good_q, busy_q, err_q, cfg_ready_q;
    logic             accept;

    // pll_lock_i is asynchronous to clkin_i
    always_ff @(posedge clkin_i or posedge reset_i) begin
        if (reset_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pll_lock_i;
            sync2_q <= sync1_q;
        end
    end
    assign lock_s = sync2_q;

    // Handshake: a request transfers on a clkin_i edge where cfg_valid_i and cfg_ready_o are both
    // high; cfg_ready_o is high only in RUN and ERROR, so requests during sequencing wait.
    assign accept = cfg_valid_i & cfg_ready_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        retry_d  = retry_q;
        idsel_d  = idsel_q;
        fbdsel_d = fbdsel_q;
        odsel_d  = odsel_q;
        case (state_q)
            S_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (lock_s) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                end else if (cnt_q == TO_LAST) begin
                    cnt_d = '0;
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + 1'b1;
                        state_d = S_RST;
                    end else begin
                        state_d = S_ERROR;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SETTLE: begin
                if (!lock_s) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RUN: begin
`ifdef PLL_DYN_CTRL_LOCK_MON_EN
                if (!lock_s) begin
                    state_d = S_RST;
                    cnt_d   = '0;
                    retry_d = '0;
                end
`endif
            end
            S_ERROR: ;
            default: begin
                state_d = S_RST;
                cnt_d   = '0;
            end
        endcase
        // An accepted request overrides lock-loss handling in RUN
        if (accept) begin
            state_d  = S_RST;
            cnt_d    = '0;
            retry_d  = '0;
            idsel_d  = cfg_idsel_i;
            fbdsel_d = cfg_fbdsel_i;
            odsel_d  = cfg_odsel_i;
        end
    end

    always_ff @(posedge clkin_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= S_RST;
            cnt_q       <= '0;
            retry_q     <= '0;
            idsel_q     <= INIT_IDSEL;
            fbdsel_q    <= INIT_FBDSEL;
            odsel_q     <= INIT_ODSEL;
            pll_reset_q <= 1'b1;
            clk_good_q  <= 1'b0;
            busy_q      <= 1'b1;
            err_q       <= 1'b0;
            cfg_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            idsel_q     <= idsel_d;
            fbdsel_q    <= fbdsel_d;
            odsel_q     <= odsel_d;
            pll_reset_q <= (state_d == S_RST) || (state_d == S_ERROR);
            clk_good_q  <= (state_d == S_RUN);
            busy_q      <= (state_d == S_RST) || (state_d == S_WAIT) || (state_d == S_SETTLE);
            err_q       <= (state_d == S_ERROR);
            cfg_ready_q <= (state_d == S_RUN) || (state_d == S_ERROR);
        end
    end

`ifdef PLL_DYN_CTRL_LOCK_MON_EN
    logic [7:0] relock_q;

    always_ff @(posedge clkin_i or posedge reset_i) begin
        if (reset_i) begin
            relock_q <= '0;
        end else if ((state_q == S_RUN) && !lock_s && !accept && (relock_q != 8'hFF)) begin
            relock_q <= relock_q + 1'b1;
        end
    end
    assign relock_cnt_o = relock_q;
`else
    assign relock_cnt_o = 8'd0;
`endif

    assign cfg_ready_o  = cfg_ready_q;
    assign pll_reset_o  = pll_reset_q;
    assign pll_idsel_o  = idsel_q;
    assign pll_fbdsel_o = fbdsel_q;
    assign pll_odsel_o  = odsel_q;
    assign clk_good_o   = clk_good_q;
    assign busy_o       = busy_q;
    assign err_o        = err_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_pll_dyn_ctrl.sv
// Bench for pll_dyn_ctrl: a PLL lock model drives pll_lock; expected output edges are queued and
// compared against the edges a monitor observes on the DUT outputs.
module tb_pll_dyn_ctrl;

    localparam int R  = 4;
    localparam int T  = 32;
    localparam int S  = 8;
    localparam int MR = 2;
    localparam int W  = 48;

    localparam logic [3:0] K_SEL  = 4'd0;
    localparam logic [3:0] K_RST  = 4'd1;
    localparam logic [3:0] K_GOOD = 4'd2;
    localparam logic [3:0] K_BUSY = 4'd3;
    localparam logic [3:0] K_ERR  = 4'd4;
    localparam logic [3:0] K_RLK  = 4'd5;

    logic       clk;
    logic       reset_i;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [5:0] cfg_idsel, cfg_fbdsel, cfg_odsel;
    logic       pll_lock;
    logic       pll_reset;
    logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;
    logic       clk_good, busy, err;
    logic [7:0] relock_cnt;
    logic [2:0] state;

    pll_dyn_ctrl #(
        .RST_CYCLES(R), .TIMEOUT_CYCLES(T), .SETTLE_CYCLES(S), .MAX_RETRY(MR), .CNT_W(16),
        .INIT_IDSEL(6'd0), .INIT_FBDSEL(6'd0), .INIT_ODSEL(6'd0)
    ) dut (
        .clkin_i(clk), .reset_i(reset_i),
        .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
        .cfg_idsel_i(cfg_idsel), .cfg_fbdsel_i(cfg_fbdsel), .cfg_odsel_i(cfg_odsel),
        .pll_lock_i(pll_lock), .pll_reset_o(pll_reset),
        .pll_idsel_o(pll_idsel), .pll_fbdsel_o(pll_fbdsel), .pll_odsel_o(pll_odsel),
        .clk_good_o(clk_good), .busy_o(busy), .err_o(err),
        .relock_cnt_o(relock_cnt), .state_o(state)
    );

    // ---------------- clock / reset / cycle count ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) begin
        if (reset_i) cyc = 0;
        else         cyc = cyc + 1;
    end

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    // ---------------- PLL lock model ----------------
    // Lock rises lock_d cycles after pll_reset falls; optional one-cycle glitch and forced drop.
    bit lock_en   = 1'b1;
    int lock_d    = 10;
    int glitch_g  = 0;
    bit drop      = 1'b0;
    int since     = 0;
    bit seen      = 1'b0;

    initial pll_lock = 1'b0;
    always @(posedge clk) begin
        #2;
        if (pll_reset) begin
            since    = 0;
            seen     = 1'b0;
            drop     = 1'b0;
            pll_lock = 1'b0;
        end else begin
            if (seen) since++;
            seen     = 1'b1;
            pll_lock = lock_en && (since >= lock_d) && !drop &&
                       !((glitch_g > 0) && (since == lock_d + glitch_g));
        end
    end

    // ---------------- scoreboard ----------------
    function automatic logic [W-1:0] ev(input int c, input logic [3:0] k, input logic [19:0] d);
        return {24'(c), k, d};
    endfunction

    task automatic push(input int c, input logic [3:0] k, input int d);
        logic [W-1:0] w;
        int i;
        w = ev(c, k, 20'(d));
        i = 0;
        while (i < exp_q.size() && exp_q[i] < w) i++;
        exp_q.insert(i, w);
    endtask

    task automatic observe(input logic [3:0] k, input logic [19:0] d);
        logic [W-1:0] got, e;
        got = ev(cyc, k, d);
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event cyc=%0d kind=%0d data=%0h expected=none", cyc, k, d);
        end else begin
            e = exp_q.pop_front();
            if (e !== got) begin
                errors++;
                $display("FAIL event actual cyc=%0d kind=%0d data=%0h expected cyc=%0d kind=%0d data=%0h",
                         got[47:24], got[23:20], got[19:0], e[47:24], e[23:20], e[19:0]);
            end
        end
    endtask

    logic [17:0] p_sel;
    logic        p_rst, p_good, p_busy, p_err;
    logic [7:0]  p_rlk;

    always @(negedge clk) begin
        if (!reset_i) begin
            if ({pll_idsel, pll_fbdsel, pll_odsel} != p_sel) observe(K_SEL, {2'b0, pll_idsel, pll_fbdsel, pll_odsel});
            if (pll_reset  != p_rst)  observe(K_RST,  {19'd0, pll_reset});
            if (clk_good   != p_good) observe(K_GOOD, {19'd0, clk_good});
            if (busy       != p_busy) observe(K_BUSY, {19'd0, busy});
            if (err        != p_err)  observe(K_ERR,  {19'd0, err});
            if (relock_cnt != p_rlk)  observe(K_RLK,  {12'd0, relock_cnt});
        end
        p_sel  = {pll_idsel, pll_fbdsel, pll_odsel};
        p_rst  = pll_reset;
        p_good = clk_good;
        p_busy = busy;
        p_err  = err;
        p_rlk  = relock_cnt;
    end

    // ---------------- reference model ----------------
    logic [17:0] cur_sel = '0;
    int          rlk_model = 0;

    // entry: 0 = already in reset pulse, 1 = leaving RUN, 2 = leaving ERROR
    task automatic predict(input int s, input int entry, output int done);
        int st, retry, f, e;
        st = s;
        retry = 0;
        done = s;
        if (entry == 1) begin
            push(s, K_RST, 1); push(s, K_GOOD, 0); push(s, K_BUSY, 1);
        end else if (entry == 2) begin
            push(s, K_BUSY, 1); push(s, K_ERR, 0);
        end
        while (1) begin
            f = st + R;
            push(f, K_RST, 0);
            if (lock_en && (lock_d + 3 <= T)) begin
                done = f + lock_d + S + 3 + ((glitch_g > 0) ? glitch_g + 1 : 0);
                push(done, K_GOOD, 1);
                push(done, K_BUSY, 0);
                break;
            end
            e = f + T;
            push(e, K_RST, 1);
            if (retry < MR) begin
                retry++;
                st = e;
            end else begin
                push(e, K_ERR, 1);
                push(e, K_BUSY, 0);
                done = e;
                break;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_until(input int c);
        int guard;
        guard = 0;
        while (cyc < c + 1 && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20000) check("wait_budget", 32'(cyc), 32'(c + 1));
    endtask

    task automatic drive_cfg(input logic [17:0] sel);
        cfg_idsel  = sel[17:12];
        cfg_fbdsel = sel[11:6];
        cfg_odsel  = sel[5:0];
    endtask

    // Called at a negedge with the DUT ready; returns at the negedge after the accepting edge.
    task automatic request(input logic [17:0] sel, input int entry, output int done);
        int a;
        a = cyc + 1;
        cfg_valid = 1'b1;
        drive_cfg(sel);
        if (sel != cur_sel) push(a, K_SEL, int'({14'd0, sel}));
        cur_sel = sel;
        predict(a, entry, done);
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_pll_reset"}, 32'(pll_reset), 32'd1);
        check({tag, "_clk_good"},  32'(clk_good),  32'd0);
        check({tag, "_busy"},      32'(busy),      32'd1);
        check({tag, "_err"},       32'(err),       32'd0);
        check({tag, "_cfg_ready"}, 32'(cfg_ready), 32'd0);
        check({tag, "_relock"},    32'(relock_cnt), 32'd0);
        check({tag, "_sel"},       32'({pll_idsel, pll_fbdsel, pll_odsel}), 32'd0);
        check({tag, "_state"},     32'(state),     32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int done, done_b, a, m, b_acc;
        logic [17:0] sel_b;
        reset_i   = 1'b1;
        cfg_valid = 1'b0;
        drive_cfg('0);
        repeat (3) @(negedge clk);
        check_reset("por");

        // power-up with lock 10 cycles after pll_reset falls
        reset_i = 1'b0;
        lock_d  = 10;
        predict(0, 0, done);
        wait_until(done);

        // directed request 3/24/8
        lock_d = $urandom_range(0, 20);
        request({6'd3, 6'd24, 6'd8}, 1, done);
        wait_until(done);

        // random requests including the lock-deadline boundary
        for (int i = 0; i < 6; i++) begin
            lock_d = (i == 0) ? T - 3 : $urandom_range(0, 25);
            request(18'($urandom), 1, done);
            wait_until(done);
        end

        // lock never asserts, then lock arriving one cycle too late
        for (int i = 0; i < 2; i++) begin
            lock_en = (i == 1);
            lock_d  = T - 2;
            request(18'($urandom), 1, done);
            wait_until(done);
            lock_en = 1'b1;
            lock_d  = $urandom_range(0, 20);
            request(18'($urandom), 2, done);
            wait_until(done);
        end

        // one-cycle lock glitch during SETTLE
        for (int i = 0; i < 3; i++) begin
            lock_d   = $urandom_range(0, 15);
            glitch_g = $urandom_range(1, S - 1);
            request(18'($urandom), 1, done);
            wait_until(done);
            glitch_g = 0;
        end

        // request held off while busy, accepted on the first ready edge
        lock_d = $urandom_range(0, 20);
        request(18'($urandom), 1, done);
        @(negedge clk);
        sel_b = 18'($urandom);
        cfg_valid = 1'b1;
        drive_cfg(sel_b);
        b_acc = done + 1;
        if (sel_b != cur_sel) push(b_acc, K_SEL, int'({14'd0, sel_b}));
        cur_sel = sel_b;
        predict(b_acc, 1, done_b);
        while (cyc < b_acc) @(negedge clk);
        cfg_valid = 1'b0;
        wait_until(done_b);

        // lock loss and request on the same edge: request wins
        m = cyc;
        drop = 1'b1;
        repeat (3) @(negedge clk);
        check("collide_setup_cyc", 32'(cyc), 32'(m + 3));
        request(18'($urandom), 1, done);
        wait_until(done);

`ifdef PLL_DYN_CTRL_LOCK_MON_EN
        // repeated lock loss in RUN, past relock_cnt saturation
        for (int i = 0; i < 258; i++) begin
            m = cyc;
            lock_d = $urandom_range(0, 3);
            drop = 1'b1;
            push(m + 4, K_RST, 1); push(m + 4, K_GOOD, 0); push(m + 4, K_BUSY, 1);
            if (rlk_model < 255) begin
                rlk_model++;
                push(m + 4, K_RLK, rlk_model);
            end
            predict(m + 4, 0, done);
            wait_until(done);
        end
        check("relock_saturated", 32'(relock_cnt), 32'd255);
`else
        drop = 1'b1;
        repeat (30) @(negedge clk);
        check("good_held_on_loss", 32'(clk_good), 32'd1);
        check("relock_tied", 32'(relock_cnt), 32'd0);
        drop = 1'b0;
        repeat (10) @(negedge clk);
`endif

        // asynchronous reset while waiting for lock
        lock_en = 1'b0;
        request(18'($urandom), 1, done);
        a = cyc;
        while (cyc < a + 8) @(negedge clk);
        check("mid_state_wait", 32'(state), 32'd1);
        @(posedge clk);
        #1;
        reset_i = 1'b1;
        #1;
        check_reset("mid");
        exp_q.delete();
        cur_sel   = '0;
        rlk_model = 0;
        lock_en   = 1'b1;
        lock_d    = $urandom_range(0, 20);
        repeat (2) @(negedge clk);
        reset_i = 1'b0;
        predict(0, 0, done);
        wait_until(done);
        request({6'd3, 6'd24, 6'd8}, 1, done);
        wait_until(done);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog cyc=%0d expected=finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule
